// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory model for the M stage.
// One load or store per request; WAIT_STATES extra cycles per access;
// MemStall holds the pipeline until the access reaches DONE.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned or
// unsupported-mask accesses on MemFault (faulting accesses touch nothing).
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStall,
  output logic        MemFault
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [3:0]            wcnt;

  // Request captured in IDLE; WAIT cycles see only these copies.
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           data_q;
  logic [3:0]            mask_q;
  logic                  write_q;

  // Values used on the access edge (live inputs when there are no wait states).
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_data;
  logic [3:0]            acc_mask;
  logic                  acc_write;
  logic                  acc_fault;
  logic                  req_fault;
  logic                  access;

  logic [31:0]           mem [0:DEPTH-1];

  // Upper address bits select nothing: the array wraps modulo its depth.
  logic                  unused_addr;
  assign unused_addr = ^{ALUResultM[31:ADDR_WIDTH+2], ALUResultM[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic fault_q;

  // Fault classification of the incoming request.
  always_comb begin
    req_fault = 1'b0;
    if ((ALUResultM[1:0] != 2'b00) && (!MemWriteM || (byteEnable == 4'b1111)))
      req_fault = 1'b1;
    if (MemWriteM && !(byteEnable inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0011, 4'b1100, 4'b1111, 4'b0000}))
      req_fault = 1'b1;
  end

  assign acc_fault = (state == ST_IDLE) ? req_fault : fault_q;

  // Fault flag latched with the request, and the one-cycle DONE pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q  <= 1'b0;
      MemFault <= 1'b0;
    end else begin
      if (state == ST_IDLE && MemReqM)
        fault_q <= req_fault;
      MemFault <= access && acc_fault;
    end
  end
`else
  assign req_fault = 1'b0;
  assign acc_fault = req_fault;
  assign MemFault  = 1'b0;
`endif

  // Access-side operand select.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_idx   = ALUResultM[ADDR_WIDTH+1:2];
      acc_data  = WriteDataM;
      acc_mask  = byteEnable;
      acc_write = MemWriteM;
    end else begin
      acc_idx   = idx_q;
      acc_data  = data_q;
      acc_mask  = mask_q;
      acc_write = write_q;
    end
  end

  // Next state, stall request and the access strobe (edge entering DONE).
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    MemStall   = 1'b0;
    access     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (MemReqM) begin
          MemStall = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = ST_DONE;
            access     = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        MemStall = 1'b1;
        if (wcnt == 4'd1) begin
          state_next = ST_DONE;
          access     = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Reset forces IDLE at once, so stall and access both drop with it.
    if (!reset) begin
      MemStall = 1'b0;
      access   = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Wait counter: loaded on acceptance, counts down through WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= 4'd0;
    end else if (state == ST_IDLE && MemReqM) begin
      wcnt <= WAIT_INIT;
    end else if (state == ST_WAIT) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // Request capture in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
    end else if (state == ST_IDLE && MemReqM) begin
      idx_q   <= ALUResultM[ADDR_WIDTH+1:2];
      data_q  <= WriteDataM;
      mask_q  <= byteEnable;
      write_q <= MemWriteM;
    end
  end

  // Array write: enabled lanes of a non-faulting store.
  // NOTE: the data array is deliberately not reset; it maps to RAM and holds its contents across reset.
  always_ff @(posedge clk) begin
    if (access && acc_write && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i])
          mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  // Load data register: updated by loads, cleared by faults, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadDataM <= '0;
    end else if (access) begin
      if (acc_fault)       ReadDataM <= '0;
      else if (!acc_write) ReadDataM <= mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset-abort and
// zero-wait back-to-back sequences, then randomized traffic against a
// word-array reference model.
module tb_dmem_responder;

  localparam int AW    = 10;
  localparam int WS    = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;

  // Instance with wait states.
  logic        MemReqM, MemWriteM;
  logic [3:0]  byteEnable;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        MemStall, MemFault;

  // Zero-wait-state instance.
  logic        req0, we0;
  logic [3:0]  be0;
  logic [31:0] addr0, wd0, rd0;
  logic        stall0, fault0;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .byteEnable(byteEnable), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .MemStall(MemStall), .MemFault(MemFault)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .MemReqM(req0), .MemWriteM(we0),
    .byteEnable(be0), .ALUResultM(addr0), .WriteDataM(wd0),
    .ReadDataM(rd0), .MemStall(stall0), .MemFault(fault0)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_rd_v,
                              input logic exp_fault_v);
    vec_t v;
    v.wr = wr; v.be = be; v.addr = addr; v.data = data;
    v.exp_rd = exp_rd_v; v.exp_fault = exp_fault_v;
    return v;
  endfunction

  // Fault rule: misaligned word-sized access, or a store mask that is not
  // a byte, an aligned halfword, a full word or empty.
  function automatic logic model_fault(input logic wr, input logic [3:0] be, input logic [31:0] a);
    logic fault;
    int   ones;
    fault = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    ones = $countones(be);
    if ((a % 4 != 0) && (!wr || be == 4'hF)) fault = 1'b1;
    if (wr && !(ones <= 1 || ones == 4 || be == 4'h3 || be == 4'hC)) fault = 1'b1;
`else
    ones = 0;
    if (wr && a[31] && be[0] && ones != 0) fault = 1'b1;
`endif
    return fault;
  endfunction

  // One access on the wait-state instance. Call just after a rising edge
  // with the FSM idle; returns just after the edge that leaves DONE.
  task automatic run_access(input string name, input logic wr, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd_seen, output logic fault_seen);
    int   stall_cycles;
    int   widx;
    logic fault_exp;
    fault_exp = model_fault(wr, be, a);
    widx      = int'((a >> 2) % DEPTH);
    MemReqM = 1'b1; MemWriteM = wr; byteEnable = be; ALUResultM = a; WriteDataM = d;
    stall_cycles = 0;
    @(negedge clk);
    while (MemStall === 1'b1 && stall_cycles < 40) begin
      stall_cycles++;
      @(posedge clk); #1;
      // Inputs are scrambled once the request is latched; they must be ignored.
      MemReqM    = 1'($urandom_range(0, 1));
      MemWriteM  = 1'($urandom_range(0, 1));
      byteEnable = 4'($urandom);
      ALUResultM = $urandom;
      WriteDataM = $urandom;
      @(negedge clk);
    end
    check({name, " stall_cycles"}, 32'(stall_cycles), 32'(WS + 1));
    if (fault_exp) begin
      exp_rd = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[widx][8*i +: 8] = d[8*i +: 8];
    end else begin
      exp_rd = model_mem[widx];
    end
    rd_seen    = ReadDataM;
    fault_seen = MemFault;
    check({name, " rdata"}, ReadDataM, exp_rd);
    check({name, " fault"}, 32'(MemFault), 32'(fault_exp));
    @(posedge clk); #1;
    MemReqM = 1'b0;
    @(negedge clk);
    check({name, " idle_fault"}, 32'(MemFault), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd_seen;
    logic        fault_seen;
    logic [31:0] z_data [0:2];

    reset = 1'b0;
    MemReqM = 1'b0; MemWriteM = 1'b0; byteEnable = 4'h0; ALUResultM = '0; WriteDataM = '0;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = '0; wd0 = '0;
    exp_rd = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset values, with a request pending: stall must still be 0.
    @(negedge clk);
    MemReqM = 1'b1;
    #1;
    check("reset rdata", ReadDataM, 32'h0);
    check("reset stall", 32'(MemStall), 32'h0);
    check("reset fault", 32'(MemFault), 32'h0);
    MemReqM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    vecs.push_back(mk(1, 4'hF, 32'h40,   32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h40,   32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 4'h1, 32'h40,   32'h000000AA, 32'h0, 0));
    vecs.push_back(mk(1, 4'h8, 32'h40,   32'h55000000, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h40,   32'h0,        32'h55ADBEAA, 0));
    vecs.push_back(mk(1, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 4'h0, 32'h0,    32'hFFFFFFFF, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 4'hF, 32'h44,   32'h11111111, 32'h0, 0));
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back(mk(1, 4'h6, 32'h44,   32'h00ABCD00, 32'h0, 1));
    vecs.push_back(mk(0, 4'hF, 32'h44,   32'h0,        32'h11111111, 0));
    vecs.push_back(mk(0, 4'hF, 32'h42,   32'h0,        32'h00000000, 1));
`else
    vecs.push_back(mk(1, 4'h6, 32'h44,   32'h00ABCD00, 32'h0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h44,   32'h0,        32'h11ABCD11, 0));
    vecs.push_back(mk(0, 4'hF, 32'h42,   32'h0,        32'h55ADBEAA, 0));
`endif
    vecs.push_back(mk(0, 4'hF, 32'h40,   32'h0,        32'h55ADBEAA, 0));

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_access(nm, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].data, rd_seen, fault_seen);
      if (!vecs[i].wr) check({nm, " table_rdata"}, rd_seen, vecs[i].exp_rd);
      check({nm, " table_fault"}, 32'(fault_seen), 32'(vecs[i].exp_fault));
    end

    // Reset during WAIT aborts the store.
    run_access("rst_pre_st", 1, 4'hF, 32'h80, 32'hA5A5A5A5, rd_seen, fault_seen);
    run_access("rst_pre_ld", 0, 4'hF, 32'h80, 32'h0,        rd_seen, fault_seen);
    MemReqM = 1'b1; MemWriteM = 1'b1; byteEnable = 4'hF; ALUResultM = 32'h80; WriteDataM = 32'h12345678;
    @(posedge clk); #1;
    MemReqM = 1'b0;
    #2;
    check("rst wait_stall", 32'(MemStall), 32'h1);
    reset = 1'b0;
    #1;
    check("rst stall_drop", 32'(MemStall), 32'h0);
    check("rst rdata_zero", ReadDataM, 32'h0);
    exp_rd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst idle_stall", 32'(MemStall), 32'h0);
    run_access("rst_post_ld", 0, 4'hF, 32'h80, 32'h0, rd_seen, fault_seen);
    check("rst prior_contents", rd_seen, 32'hA5A5A5A5);

    // Zero wait states: back-to-back stores then loads, stall 1,0 per request.
    z_data[0] = 32'h0BADF00D; z_data[1] = 32'h13579BDF; z_data[2] = 32'h2468ACE0;
    for (int k = 0; k < 6; k++) begin
      req0  = 1'b1;
      we0   = (k < 3);
      be0   = 4'hF;
      addr0 = 32'h10 + 32'((k % 3) * 4);
      wd0   = z_data[k % 3];
      @(negedge clk);
      check($sformatf("zws%0d stall_req", k), 32'(stall0), 32'h1);
      @(posedge clk); #1;
      req0 = 1'b0;
      addr0 = $urandom;
      wd0   = $urandom;
      @(negedge clk);
      check($sformatf("zws%0d stall_done", k), 32'(stall0), 32'h0);
      if (k >= 3) check($sformatf("zws%0d rdata", k), rd0, z_data[k % 3]);
      @(posedge clk); #1;
    end

    // Randomized traffic on eight words, with random upper address bits.
    for (int k = 0; k < 8; k++)
      run_access($sformatf("rinit%0d", k), 1, 4'hF, 32'(32'h400 + k * 4), $urandom, rd_seen, fault_seen);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [1:0]  low;
      low = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      a   = ($urandom & 32'hFFFF_F000) | 32'(32'h400 + $urandom_range(0, 7) * 4) | 32'(low);
      run_access($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom,
                 rd_seen, fault_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the memory-stage side of the pipelined datapath. It accepts one load or store per request from the M stage (address `ALUResultM`, store data `WriteDataM`, lane mask `byteEnable`), models a fixed-latency data memory with configurable wait states, and returns `ReadDataM`. It asserts `MemStall` so that the hazard logic freezes the pipeline until the access completes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: number of word-address bits (memory depth is 2^ADDR_WIDTH words of 32 bits).
- `WAIT_STATES`, default 2: extra cycles inserted per access (range 0–15).

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemReqM` in 1: M-stage access valid (load or store).
- `MemWriteM` in 1: 1 = store, 0 = load.
- `byteEnable` in 4: store lane mask. Bit i enables bits [8i+7:8i].
- `ALUResultM` in 32: byte address.
- `WriteDataM` in 32: store data, lane-aligned.
- `ReadDataM` out 32: registered load data.
- `MemStall` out 1: pipeline hold request.
- `MemFault` out 1: access fault pulse. Constant 0 unless `DMEM_ALIGN_CHECK_EN` is defined.

## Operation
- FSM states: IDLE, WAIT, DONE. A 4-bit wait counter `wcnt` runs alongside the FSM.
- IDLE with `MemReqM`=1:
  - Latch address, data, mask and write flag.
  - Load `wcnt`=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise go to DONE.
- IDLE with `MemReqM`=0: stay in IDLE.
- WAIT: decrement `wcnt`. On the edge where `wcnt`==1, go to DONE.
- Access point: the array access happens on the edge that enters DONE, and uses only the latched values.
  - Store: write only the enabled lanes. A mask of 0000 completes with no array change.
  - Load: capture the full word into `ReadDataM`.
- DONE: go to IDLE unconditionally. If `MemReqM` is 1 in the next IDLE cycle, it is a new request.
- Word index is `ALUResultM[ADDR_WIDTH+1:2]`. Upper bits are ignored, so addresses wrap modulo the memory size.
- Input changes while in WAIT are ignored; the latched request is used.
- `ReadDataM` holds its value until the next load completes. Stores do not change it.
- `MemStall` is combinational:
  - 1 in IDLE when `MemReqM`=1.
  - 1 in WAIT.
  - 0 in DONE.
  - 0 while `reset` is low.

## Timing
- A request first seen in cycle T keeps `MemStall` high for cycles T..T+WAIT_STATES, which is WAIT_STATES+1 cycles.
- DONE occurs in cycle T+WAIT_STATES+1. In DONE, `ReadDataM` is valid and `MemStall` is 0; the pipeline advances on the edge that ends DONE.
- Back-to-back requests: the second request is seen in IDLE at T+WAIT_STATES+2, so throughput is one access per WAIT_STATES+2 cycles.
- Reset values: state=IDLE, `wcnt`=0, `ReadDataM`=0, `MemStall`=0, `MemFault`=0. Array contents are not reset.
- Reset asserted before the access edge aborts the request: no array write, and `ReadDataM` goes to 0. After release, the FSM is in IDLE.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- When defined, a request is faulting if either condition holds:
  - `ALUResultM[1:0]`≠00 and the access is a load or a store with mask 1111.
  - A store mask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111, 0000.
- A faulting request follows the identical FSM timing, with these differences:
  - No array write.
  - `ReadDataM` is loaded with 0.
  - `MemFault`=1 for exactly the DONE cycle (registered).
- When not defined: `MemFault` is tied to 0, `ALUResultM[1:0]` is ignored, and every mask is honoured as given.

## Test plan
1. WAIT_STATES=2. Store word 0xDEADBEEF to 0x40, then load 0x40.
   Required: `MemStall` high for 3 cycles per access, `ReadDataM`=0xDEADBEEF in the load's DONE cycle.
2. Mem[0x40]=0xDEADBEEF. Store 0x000000AA with mask 0001, then store 0x55000000 with mask 1000, then load.
   Required: `ReadDataM`=0x55ADBEAA.
3. WAIT_STATES=0. Issue 3 back-to-back loads.
   Required: `MemStall` alternates 1,0 per request; each access completes 2 cycles after it is first seen.
4. Store 0x12345678 to 0x80, then assert `reset` low during WAIT.
   Required: `MemStall` drops immediately; a subsequent load of 0x80 returns the prior contents; `ReadDataM`=0 right after reset.
5. ADDR_WIDTH=10. Store 0xCAFEF00D to 0x1000, then load 0x0000.
   Required: `ReadDataM`=0xCAFEF00D (wrap-around).
6. With `DMEM_ALIGN_CHECK_EN` defined, load from 0x42.
   Required: `MemFault`=1 in DONE only, `ReadDataM`=0, array unchanged.
   Without the macro, the same load returns the word at 0x40 and `MemFault` stays 0.
